// File: rtl/sdram_wr_burst_src.sv
`default_nettype none
// ============================================================================
// Module  : sdram_wr_burst_src
// Purpose : Show-ahead write FIFO that issues fixed-length SDRAM burst
//           requests and walks the burst address through a wrapping window.
// Rev     : 1.0
// ============================================================================
module sdram_wr_burst_src #(
  parameter int          DATA_W     = 16,
  parameter int          FIFO_DEPTH = 512,
  parameter int          BURST_LEN  = 64,
  parameter logic [23:0] ADDR_MIN   = 24'h000000,
  parameter logic [23:0] ADDR_MAX   = 24'h00FFFF
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          init_end,
  input  logic                          usr_wr_en,
  input  logic [DATA_W-1:0]             usr_wr_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          wr_en,
  output logic [23:0]                   addr,
  output logic [9:0]                    wr_burst_len,
  output logic [DATA_W-1:0]             data,
  input  logic                          wr_ack,
  input  logic                          wr_end,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int                PTR_W       = $clog2(FIFO_DEPTH);
  localparam int                LVL_W       = PTR_W + 1;
  localparam logic [LVL_W-1:0]  DEPTH_LVL   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  BURST_LVL   = LVL_W'(BURST_LEN);
  localparam logic [9:0]        BURST_LEN_C = 10'(BURST_LEN);
  localparam logic [23:0]       STEP_24     = 24'(BURST_LEN);
  localparam logic [24:0]       STEP_25     = 25'(BURST_LEN);
  localparam logic [24:0]       ADDR_MAX_25 = {1'b0, ADDR_MAX};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_en_q, wr_en_d;
  logic [23:0]       addr_q, addr_d;
  logic [9:0]        ack_cnt_q, ack_cnt_d;
  state_t            state_q, state_d;

  logic              empty, full, push, pop;
  logic [24:0]       addr_sum;

  assign empty = (level_q == '0);
  assign full  = (level_q == DEPTH_LVL);
  assign pop   = wr_ack && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = usr_wr_en && (!full || pop);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q  | (usr_wr_en & full & ~pop);
    underflow_d = underflow_q | (wr_ack & empty);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  assign addr_sum = {1'b0, addr_q} + STEP_25;

  always_comb begin
    state_d   = state_q;
    wr_en_d   = wr_en_q;
    addr_d    = addr_q;
    ack_cnt_d = ack_cnt_q;
    case (state_q)
      IDLE: begin
        ack_cnt_d = '0;
        if (init_end && (level_q >= BURST_LVL)) begin
          state_d = REQ;
          wr_en_d = 1'b1;
        end
      end
      REQ: begin
        if (wr_ack) begin
          state_d   = BURST;
          ack_cnt_d = 10'd1;
        end
      end
      BURST: begin
        if (wr_ack && (ack_cnt_q != BURST_LEN_C)) ack_cnt_d = ack_cnt_q + 10'd1;
        if (wr_end) begin
          wr_en_d = 1'b0;
          addr_d  = (addr_sum > ADDR_MAX_25) ? ADDR_MIN : (addr_q + STEP_24);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= ADDR_MIN;
      ack_cnt_q   <= '0;
      state_q     <= IDLE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      ack_cnt_q   <= ack_cnt_d;
      state_q     <= state_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && push) mem_q[wr_ptr_q] <= usr_wr_data;
  end

  assign data         = empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_level   = level_q;
  assign fifo_full    = full;
  assign wr_en        = wr_en_q;
  assign addr         = addr_q;
  assign wr_burst_len = BURST_LEN_C;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_wr_burst_src.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_wr_burst_src
// Purpose : Self-checking bench; vector table plus scoreboarded burst sequences.
// Rev     : 1.0
// ============================================================================
module tb_sdram_wr_burst_src;

  localparam int DEPTH = 512;
  localparam int BLEN  = 64;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic        usr_wr_en;
  logic [15:0] usr_wr_data;
  logic        fifo_full;
  logic [9:0]  fifo_level;
  logic        wr_en;
  logic [23:0] addr;
  logic [9:0]  wr_burst_len;
  logic [15:0] data;
  logic        wr_ack;
  logic        wr_end;
  logic        overflow;
  logic        underflow;

  sdram_wr_burst_src #(
    .DATA_W     (16),
    .FIFO_DEPTH (DEPTH),
    .BURST_LEN  (BLEN),
    .ADDR_MIN   (24'h000000),
    .ADDR_MAX   (24'h0000FF)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .init_end     (init_end),
    .usr_wr_en    (usr_wr_en),
    .usr_wr_data  (usr_wr_data),
    .fifo_full    (fifo_full),
    .fifo_level   (fifo_level),
    .wr_en        (wr_en),
    .addr         (addr),
    .wr_burst_len (wr_burst_len),
    .data         (data),
    .wr_ack       (wr_ack),
    .wr_end       (wr_end),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] sb[$];
  logic        exp_of;
  logic        exp_uf;
  logic [23:0] model_addr;

  typedef struct {
    logic        we;
    logic [15:0] wd;
    logic        ack;
    logic        wend;
    int          exp_level;
    logic        exp_wr_en;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: drive at posedge+1, check show-ahead data, then registered outputs.
  task automatic cyc(input logic we, input logic [15:0] wd, input logic ack, input logic wend);
    int          sz;
    logic [15:0] e;
    usr_wr_en   = we;
    usr_wr_data = wd;
    wr_ack      = ack;
    wr_end      = wend;
    sz = sb.size();
    if (ack) begin
      e = (sz > 0) ? sb.pop_front() : 16'h0000;
      check("data", 32'(data), 32'(e));
      if (sz == 0) exp_uf = 1'b1;
    end
    if (we && (sz < DEPTH || (ack && sz > 0))) sb.push_back(wd);
    else if (we) exp_of = 1'b1;
    @(posedge sys_clk); #1;
    usr_wr_en = 1'b0;
    wr_ack    = 1'b0;
    wr_end    = 1'b0;
    check("fifo_level", 32'(fifo_level), 32'(sb.size()));
    check("fifo_full",  32'(fifo_full),  32'(sb.size() == DEPTH));
    check("overflow",   32'(overflow),   32'(exp_of));
    check("underflow",  32'(underflow),  32'(exp_uf));
  endtask

  task automatic do_reset();
    sys_rst   = 1'b1;
    usr_wr_en = 1'b1;
    wr_ack    = 1'b1;
    wr_end    = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst   = 1'b0;
    usr_wr_en = 1'b0;
    wr_ack    = 1'b0;
    wr_end    = 1'b0;
    sb.delete();
    exp_of     = 1'b0;
    exp_uf     = 1'b0;
    model_addr = 24'h000000;
    check("rst_level",   32'(fifo_level),   32'd0);
    check("rst_full",    32'(fifo_full),    32'd0);
    check("rst_wr_en",   32'(wr_en),        32'd0);
    check("rst_addr",    32'(addr),         32'h0);
    check("rst_of",      32'(overflow),     32'd0);
    check("rst_uf",      32'(underflow),    32'd0);
    check("rst_data",    32'(data),         32'd0);
    check("burst_len",   32'(wr_burst_len), 32'd64);
  endtask

  task automatic wait_wr_en();
    for (int i = 0; i < 8; i++) begin
      if (wr_en) break;
      cyc(1'b0, 16'h0, 1'b0, 1'b0);
    end
    check("wr_en_rise", 32'(wr_en), 32'd1);
  endtask

  // Full burst; wr_end coincides with the last ack.
  task automatic run_burst();
    for (int i = 0; i < BLEN; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    wait_wr_en();
    check("burst_addr", 32'(addr), 32'(model_addr));
    for (int i = 0; i < BLEN; i++) begin
      cyc(1'b0, 16'h0, 1'b1, (i == BLEN - 1));
      if (i < BLEN - 1) check("burst_wr_en_hold", 32'(wr_en), 32'd1);
    end
    model_addr = (model_addr + 24'd64 > 24'h0000FF) ? 24'h000000 : model_addr + 24'd64;
    check("burst_end_wr_en", 32'(wr_en), 32'd0);
    check("burst_end_addr",  32'(addr),  32'(model_addr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sys_rst = 1'b1; init_end = 1'b0;
    usr_wr_en = 1'b0; usr_wr_data = 16'h0; wr_ack = 1'b0; wr_end = 1'b0;
    exp_of = 1'b0; exp_uf = 1'b0; model_addr = 24'h0;
    repeat (2) @(posedge sys_clk);
    #1;
    init_end = 1'b1;
    do_reset();

    // Short vectors: empty ack, push/pop overlap, stray wr_end in IDLE.
    vecs[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b1, 16'hA001, 1'b0, 1'b0, 1, 1'b0};
    vecs[2] = '{1'b1, 16'hA002, 1'b1, 1'b0, 1, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0};
    vecs[4] = '{1'b1, 16'hA003, 1'b0, 1'b1, 1, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      cyc(vecs[i].we, vecs[i].wd, vecs[i].ack, vecs[i].wend);
      check("vec_level", 32'(fifo_level), 32'(vecs[i].exp_level));
      check("vec_wr_en", 32'(wr_en),      32'(vecs[i].exp_wr_en));
    end
    check("vec_addr", 32'(addr),      32'h0);
    check("vec_uf",   32'(underflow), 32'd1);

    // Threshold: 63 words never request; the 64th does, one cycle later.
    do_reset();
    for (int i = 1; i <= 63; i++) begin
      cyc(1'b1, 16'(i), 1'b0, 1'b0);
      check("below_thresh_wr_en", 32'(wr_en), 32'd0);
    end
    cyc(1'b1, 16'h0040, 1'b0, 1'b0);
    check("lvl64_wr_en_still_0", 32'(wr_en), 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    check("req_wr_en", 32'(wr_en), 32'd1);
    check("req_addr",  32'(addr),  32'h0);

    // Drain the burst, then a separate wr_end.
    for (int i = 0; i < BLEN; i++) begin
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      check("ack_wr_en", 32'(wr_en), 32'd1);
      check("ack_addr",  32'(addr),  32'h0);
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    check("end_wr_en", 32'(wr_en), 32'd0);
    check("end_addr",  32'(addr),  32'h40);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    check("idle_wr_en", 32'(wr_en), 32'd0);

    // Window walk 0x40 -> 0x80 -> 0xC0 -> wrap to 0x00.
    model_addr = 24'h000040;
    repeat (3) run_burst();
    check("wrap_addr", 32'(addr), 32'h0);

    // Overflow and push-while-full with pop; requests gated off by init_end.
    do_reset();
    init_end = 1'b0;
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'(i + 16'h1000), 1'b0, 1'b0);
    check("fill_wr_en", 32'(wr_en), 32'd0);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("ovf_flag",  32'(overflow),   32'd1);
    check("ovf_level", 32'(fifo_level), 32'd512);
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check("full_pushpop_level", 32'(fifo_level), 32'd512);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("empty_ack_uf",    32'(underflow),  32'd1);
    check("empty_ack_level", 32'(fifo_level), 32'd0);

    // Reset mid-burst after a completed burst moved the address.
    do_reset();
    init_end = 1'b1;
    run_burst();
    for (int i = 0; i < BLEN; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    wait_wr_en();
    for (int i = 0; i < 10; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("pre_rst_addr", 32'(addr), 32'h40);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b0);
      check("post_rst_no_req", 32'(wr_en), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
